// File: rtl/id_ex_stage_if.sv
// ---------------------------------------------------------------------------
// id_ex_stage_if : signal bundle between ID, the ID/EX register, the later
// pipeline stages (forwarding sources) and the ALU.
//   flush_i / stall_i       : pipeline control into ID/EX
//   id_*                    : decoded operands/control from ID
//   exmem_* / memwb_*       : write-back claims of the downstream stages
//   alu_* / store_data_o    : operands for the ALU and the store path
//   ex_*                    : registered destination and control bits
//   load_use_stall_o        : freeze PC and IF/ID this cycle
//   ill_op_o                : sticky illegal-op flag
// master = environment (ID/EX/MEM/WB/ALU side), slave = id_ex_stage.
// ---------------------------------------------------------------------------
interface id_ex_stage_if #(
  parameter int DW = 32,
  parameter int RW = 5
);
  logic          flush_i;
  logic          stall_i;
  logic [DW-1:0] id_rs_data_i;
  logic [DW-1:0] id_rt_data_i;
  logic [DW-1:0] id_imm_i;
  logic [RW-1:0] id_rs_i;
  logic [RW-1:0] id_rt_i;
  logic [RW-1:0] id_rd_i;
  logic [3:0]    id_alu_op_i;
  logic          id_alu_src_i;
  logic          id_reg_write_i;
  logic          id_mem_read_i;
  logic          id_mem_write_i;
  logic          id_mem_to_reg_i;
  logic          exmem_reg_write_i;
  logic [RW-1:0] exmem_rd_i;
  logic [DW-1:0] exmem_result_i;
  logic          memwb_reg_write_i;
  logic [RW-1:0] memwb_rd_i;
  logic [DW-1:0] memwb_data_i;
  logic [DW-1:0] alu_a_o;
  logic [DW-1:0] alu_b_o;
  logic [3:0]    alu_op_o;
  logic [DW-1:0] store_data_o;
  logic [RW-1:0] ex_rd_o;
  logic          ex_reg_write_o;
  logic          ex_mem_read_o;
  logic          ex_mem_write_o;
  logic          ex_mem_to_reg_o;
  logic          load_use_stall_o;
  logic          ill_op_o;

  modport master (
    output flush_i, stall_i,
           id_rs_data_i, id_rt_data_i, id_imm_i, id_rs_i, id_rt_i, id_rd_i,
           id_alu_op_i, id_alu_src_i, id_reg_write_i, id_mem_read_i,
           id_mem_write_i, id_mem_to_reg_i,
           exmem_reg_write_i, exmem_rd_i, exmem_result_i,
           memwb_reg_write_i, memwb_rd_i, memwb_data_i,
    input  alu_a_o, alu_b_o, alu_op_o, store_data_o, ex_rd_o,
           ex_reg_write_o, ex_mem_read_o, ex_mem_write_o, ex_mem_to_reg_o,
           load_use_stall_o, ill_op_o
  );

  modport slave (
    input  flush_i, stall_i,
           id_rs_data_i, id_rt_data_i, id_imm_i, id_rs_i, id_rt_i, id_rd_i,
           id_alu_op_i, id_alu_src_i, id_reg_write_i, id_mem_read_i,
           id_mem_write_i, id_mem_to_reg_i,
           exmem_reg_write_i, exmem_rd_i, exmem_result_i,
           memwb_reg_write_i, memwb_rd_i, memwb_data_i,
    output alu_a_o, alu_b_o, alu_op_o, store_data_o, ex_rd_o,
           ex_reg_write_o, ex_mem_read_o, ex_mem_write_o, ex_mem_to_reg_o,
           load_use_stall_o, ill_op_o
  );
endinterface

// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage : ID/EX pipeline register with EX-stage operand forwarding,
// load-use hazard detection and ALU op screening.
//   clk, rst_n : rising-edge clock, asynchronous active-low reset
//   bus        : id_ex_stage_if.slave (ID inputs, EX/MEM + MEM/WB forwarding
//                sources, ALU operands, registered control, hazard/ill flags)
// Register update priority: flush > stall > load-use bubble > load.
// An illegal op on load becomes a bubble and sets the sticky ill_op_o.
// ---------------------------------------------------------------------------

// Per-operand forwarding mux: newest producer (EX/MEM) wins over MEM/WB,
// register 0 is never forwarded.
module id_ex_fwd #(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic [RW-1:0] src_i,
  input  logic [DW-1:0] reg_i,
  input  logic          exmem_we_i,
  input  logic [RW-1:0] exmem_rd_i,
  input  logic [DW-1:0] exmem_res_i,
  input  logic          memwb_we_i,
  input  logic [RW-1:0] memwb_rd_i,
  input  logic [DW-1:0] memwb_data_i,
  output logic [DW-1:0] val_o
);
  always_comb begin
    val_o = reg_i;
    if (memwb_we_i && (memwb_rd_i != '0) && (memwb_rd_i == src_i)) val_o = memwb_data_i;
    if (exmem_we_i && (exmem_rd_i != '0) && (exmem_rd_i == src_i)) val_o = exmem_res_i;
  end
endmodule

module id_ex_stage #(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  id_ex_stage_if.slave bus
);
  localparam int NUM_OPS = 2; // 0 = rs, 1 = rt

  typedef struct packed {
    logic [DW-1:0] rs_data;
    logic [DW-1:0] rt_data;
    logic [DW-1:0] imm;
    logic [RW-1:0] rs;
    logic [RW-1:0] rt;
    logic [RW-1:0] rd;
    logic [3:0]    op;
    logic          alu_src;
    logic          reg_write;
    logic          mem_read;
    logic          mem_write;
    logic          mem_to_reg;
  } ex_t;

  ex_t  ex_q, ex_d, id_pkt;
  logic ill_q, ill_d;
  logic op_legal, load_use;

  logic [NUM_OPS-1:0][RW-1:0] fwd_src;
  logic [NUM_OPS-1:0][DW-1:0] fwd_reg;
  logic [NUM_OPS-1:0][DW-1:0] fwd_val;

  assign id_pkt = '{
    rs_data:    bus.id_rs_data_i,
    rt_data:    bus.id_rt_data_i,
    imm:        bus.id_imm_i,
    rs:         bus.id_rs_i,
    rt:         bus.id_rt_i,
    rd:         bus.id_rd_i,
    op:         bus.id_alu_op_i,
    alu_src:    bus.id_alu_src_i,
    reg_write:  bus.id_reg_write_i,
    mem_read:   bus.id_mem_read_i,
    mem_write:  bus.id_mem_write_i,
    mem_to_reg: bus.id_mem_to_reg_i
  };

  always_comb begin
    op_legal = 1'b0;
    case (bus.id_alu_op_i)
      4'b0000, 4'b0100, 4'b0001, 4'b0101, 4'b0010, 4'b0110: op_legal = 1'b1;
      default: op_legal = 1'b0;
    endcase
  end

  // Load in EX whose destination is read by the instruction now in ID.
  assign load_use = ex_q.mem_read && (ex_q.rd != '0) &&
                    ((ex_q.rd == bus.id_rs_i) || (ex_q.rd == bus.id_rt_i));

  always_comb begin
    ex_d  = ex_q;
    ill_d = ill_q;
    if (bus.flush_i) begin
      ex_d = '0;
    end else if (bus.stall_i) begin
      ex_d = ex_q;
    end else if (load_use) begin
      ex_d = '0;
    end else if (!op_legal) begin
      ex_d  = '0;
      ill_d = 1'b1;
    end else begin
      ex_d = id_pkt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q  <= '0;
      ill_q <= 1'b0;
    end else begin
      ex_q  <= ex_d;
      ill_q <= ill_d;
    end
  end

  assign fwd_src[0] = ex_q.rs;
  assign fwd_reg[0] = ex_q.rs_data;
  assign fwd_src[1] = ex_q.rt;
  assign fwd_reg[1] = ex_q.rt_data;

  // Forwarding is re-evaluated every cycle, so held contents track the
  // downstream stages while stalled.
  for (genvar g = 0; g < NUM_OPS; g++) begin : g_fwd
    id_ex_fwd #(.DW(DW), .RW(RW)) u_fwd (
      .src_i        (fwd_src[g]),
      .reg_i        (fwd_reg[g]),
      .exmem_we_i   (bus.exmem_reg_write_i),
      .exmem_rd_i   (bus.exmem_rd_i),
      .exmem_res_i  (bus.exmem_result_i),
      .memwb_we_i   (bus.memwb_reg_write_i),
      .memwb_rd_i   (bus.memwb_rd_i),
      .memwb_data_i (bus.memwb_data_i),
      .val_o        (fwd_val[g])
    );
  end

  assign bus.alu_a_o          = fwd_val[0];
  // Store data always takes the forwarded rt, even when B is the immediate.
  assign bus.alu_b_o          = ex_q.alu_src ? ex_q.imm : fwd_val[1];
  assign bus.store_data_o     = fwd_val[1];
  assign bus.alu_op_o         = ex_q.op;
  assign bus.ex_rd_o          = ex_q.rd;
  assign bus.ex_reg_write_o   = ex_q.reg_write;
  assign bus.ex_mem_read_o    = ex_q.mem_read;
  assign bus.ex_mem_write_o   = ex_q.mem_write;
  assign bus.ex_mem_to_reg_o  = ex_q.mem_to_reg;
  assign bus.load_use_stall_o = load_use;
  assign bus.ill_op_o         = ill_q;
endmodule

// File: tb/tb_id_ex_stage.sv
// ---------------------------------------------------------------------------
// tb_id_ex_stage : scoreboard bench for id_ex_stage. The driver applies one
// stimulus per cycle, computes the expected outputs from a behavioural model
// of the EX-stage contents and pushes them into a queue; a negedge monitor
// pops and compares against the DUT.
// ---------------------------------------------------------------------------
module tb_id_ex_stage;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  id_ex_stage_if #(.DW(32), .RW(5)) bus ();
  id_ex_stage #(.DW(32), .RW(5)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    logic [31:0] rs_data, rt_data, imm;
    logic [4:0]  rs, rt, rd;
    logic [3:0]  op;
    logic        alu_src, rw, mr, mw, m2r;
  } ex_t;

  typedef struct {
    logic        flush, stall;
    ex_t         id;
    logic        exw;
    logic [4:0]  exrd;
    logic [31:0] exres;
    logic        mww;
    logic [4:0]  mwrd;
    logic [31:0] mwdata;
  } stim_t;

  typedef struct {
    logic [31:0] a, b, store;
    logic [3:0]  op;
    logic [4:0]  rd;
    logic        rw, mr, mw, m2r, lus, ill;
  } exp_t;

  ex_t  m;          // what EX holds now
  logic m_ill;
  exp_t q[$];
  exp_t mon_e;
  int   checks = 0;
  int   failures = 0;

  task automatic chk(string n, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s act=%h req=%h", n, act, req);
    end
  endtask

  function automatic ex_t bubble();
    ex_t b;
    b = '{default: '0};
    return b;
  endfunction

  function automatic logic legal(logic [3:0] op);
    return op inside {4'b0000, 4'b0100, 4'b0001, 4'b0101, 4'b0010, 4'b0110};
  endfunction

  // Value a reader of register a sees: newest pending write wins, r0 is fixed.
  function automatic logic [31:0] fwd(stim_t s, logic [4:0] a, logic [31:0] r);
    logic        we[2];
    logic [4:0]  rd[2];
    logic [31:0] v[2];
    we = '{s.exw, s.mww};
    rd = '{s.exrd, s.mwrd};
    v  = '{s.exres, s.mwdata};
    for (int i = 0; i < 2; i++)
      if (we[i] && rd[i] != 0 && rd[i] == a) return v[i];
    return r;
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s.flush = 0; s.stall = 0; s.id = bubble();
    s.exw = 0; s.exrd = 0; s.exres = 0;
    s.mww = 0; s.mwrd = 0; s.mwdata = 0;
    return s;
  endfunction

  function automatic stim_t rnd();
    stim_t s;
    logic [3:0] lg[6];
    lg = '{4'b0000, 4'b0100, 4'b0001, 4'b0101, 4'b0010, 4'b0110};
    s.flush      = ($urandom_range(9, 0) == 0);
    s.stall      = ($urandom_range(6, 0) == 0);
    s.id.rs_data = $urandom;
    s.id.rt_data = $urandom;
    s.id.imm     = $urandom;
    s.id.rs      = 5'($urandom_range(7, 0));
    s.id.rt      = 5'($urandom_range(7, 0));
    s.id.rd      = 5'($urandom_range(7, 0));
    s.id.op      = ($urandom_range(11, 0) == 0) ? 4'($urandom) : lg[$urandom_range(5, 0)];
    s.id.alu_src = 1'($urandom);
    s.id.rw      = 1'($urandom);
    s.id.mr      = ($urandom_range(2, 0) == 0);
    s.id.mw      = 1'($urandom);
    s.id.m2r     = 1'($urandom);
    s.exw        = 1'($urandom);
    s.exrd       = 5'($urandom_range(7, 0));
    s.exres      = $urandom;
    s.mww        = 1'($urandom);
    s.mwrd       = 5'($urandom_range(7, 0));
    s.mwdata     = $urandom;
    return s;
  endfunction

  task automatic drive(stim_t s);
    bus.flush_i           = s.flush;
    bus.stall_i           = s.stall;
    bus.id_rs_data_i      = s.id.rs_data;
    bus.id_rt_data_i      = s.id.rt_data;
    bus.id_imm_i          = s.id.imm;
    bus.id_rs_i           = s.id.rs;
    bus.id_rt_i           = s.id.rt;
    bus.id_rd_i           = s.id.rd;
    bus.id_alu_op_i       = s.id.op;
    bus.id_alu_src_i      = s.id.alu_src;
    bus.id_reg_write_i    = s.id.rw;
    bus.id_mem_read_i     = s.id.mr;
    bus.id_mem_write_i    = s.id.mw;
    bus.id_mem_to_reg_i   = s.id.m2r;
    bus.exmem_reg_write_i = s.exw;
    bus.exmem_rd_i        = s.exrd;
    bus.exmem_result_i    = s.exres;
    bus.memwb_reg_write_i = s.mww;
    bus.memwb_rd_i        = s.mwrd;
    bus.memwb_data_i      = s.mwdata;
  endtask

  // One clock of stimulus: called just after a posedge, returns just after the next.
  task automatic cycle(stim_t s);
    exp_t        e;
    ex_t         nxt;
    logic        nill;
    logic [31:0] rt_v;
    drive(s);
    rt_v    = fwd(s, m.rt, m.rt_data);
    e.a     = fwd(s, m.rs, m.rs_data);
    e.b     = m.alu_src ? m.imm : rt_v;
    e.store = rt_v;
    e.op    = m.op;
    e.rd    = m.rd;
    e.rw    = m.rw; e.mr = m.mr; e.mw = m.mw; e.m2r = m.m2r;
    e.lus   = m.mr && m.rd != 0 && (m.rd == s.id.rs || m.rd == s.id.rt);
    e.ill   = m_ill;
    q.push_back(e);
    nxt  = m;
    nill = m_ill;
    if (s.flush)               nxt = bubble();
    else if (s.stall)          nxt = m;
    else if (e.lus)            nxt = bubble();
    else if (!legal(s.id.op)) begin nxt = bubble(); nill = 1'b1; end
    else                       nxt = s.id;
    @(posedge clk);
    m     = nxt;
    m_ill = nill;
    #1;
  endtask

  always @(negedge clk) begin
    if (rst_n && q.size() > 0) begin
      mon_e = q.pop_front();
      chk("alu_a",   bus.alu_a_o,                 mon_e.a);
      chk("alu_b",   bus.alu_b_o,                 mon_e.b);
      chk("store",   bus.store_data_o,            mon_e.store);
      chk("alu_op",  32'(bus.alu_op_o),           32'(mon_e.op));
      chk("ex_rd",   32'(bus.ex_rd_o),            32'(mon_e.rd));
      chk("ctrl",    32'({bus.ex_reg_write_o, bus.ex_mem_read_o, bus.ex_mem_write_o,
                          bus.ex_mem_to_reg_o}),
                     32'({mon_e.rw, mon_e.mr, mon_e.mw, mon_e.m2r}));
      chk("lus",     32'(bus.load_use_stall_o),   32'(mon_e.lus));
      chk("ill",     32'(bus.ill_op_o),           32'(mon_e.ill));
    end
  end

  task automatic chk_zero(string n);
    chk({n, "_a"},     bus.alu_a_o, 0);
    chk({n, "_b"},     bus.alu_b_o, 0);
    chk({n, "_op"},    32'(bus.alu_op_o), 0);
    chk({n, "_store"}, bus.store_data_o, 0);
    chk({n, "_rd"},    32'(bus.ex_rd_o), 0);
    chk({n, "_ctrl"},  32'({bus.ex_reg_write_o, bus.ex_mem_read_o, bus.ex_mem_write_o,
                            bus.ex_mem_to_reg_o}), 0);
    chk({n, "_lus"},   32'(bus.load_use_stall_o), 0);
    chk({n, "_ill"},   32'(bus.ill_op_o), 0);
  endtask

  stim_t s;

  initial begin
    m = bubble();
    m_ill = 1'b0;
    rst_n = 1'b0;
    drive(idle());
    #12;
    chk_zero("reset");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk) #1;

    // sub with no forwarding
    s = idle();
    s.id.rs = 1; s.id.rs_data = 5; s.id.rt = 2; s.id.rt_data = 7;
    s.id.op = 4'b0100; s.id.rw = 1; s.id.rd = 9;
    cycle(s);
    chk("tp_sub_a",  bus.alu_a_o, 5);
    chk("tp_sub_b",  bus.alu_b_o, 7);
    chk("tp_sub_op", 32'(bus.alu_op_o), 32'h4);
    cycle(idle());

    // forwarding priority on a held rs=3
    s = idle();
    s.id.rs = 3; s.id.rs_data = 32'h33; s.id.rw = 1; s.id.rd = 6;
    cycle(s);
    s = idle();
    s.stall = 1;
    s.exw = 1; s.exrd = 3; s.exres = 32'h11;
    s.mww = 1; s.mwrd = 3; s.mwdata = 32'h22;
    drive(s); #1 chk("fwd_exmem", bus.alu_a_o, 32'h11);
    cycle(s);
    s.exw = 0;
    drive(s); #1 chk("fwd_memwb", bus.alu_a_o, 32'h22);
    cycle(s);
    s.exw = 1; s.exrd = 0; s.mwrd = 0;
    drive(s); #1 chk("fwd_r0", bus.alu_a_o, 32'h33);
    cycle(s);

    // load-use
    s = idle(); s.id.mr = 1; s.id.rw = 1; s.id.rd = 4; s.id.m2r = 1;
    cycle(s);
    s = idle(); s.id.rs = 4; s.id.rw = 1; s.id.rd = 5;
    drive(s); #1 chk("lus_hit", 32'(bus.load_use_stall_o), 1);
    cycle(s);
    chk("lus_bubble", 32'(bus.ex_reg_write_o), 0);
    s = idle(); s.id.mr = 1; s.id.rw = 1; s.id.rd = 0;
    cycle(s);
    s = idle(); s.id.rs = 0; s.id.rw = 1; s.id.rd = 5;
    drive(s); #1 chk("lus_r0", 32'(bus.load_use_stall_o), 0);
    cycle(s);

    // flush beats stall; stall holds and tracks MEM/WB
    s = idle(); s.flush = 1; s.stall = 1; s.id.rw = 1; s.id.rd = 7; s.id.rs = 2;
    s.id.rs_data = 32'hAB;
    cycle(s);
    chk("flush_stall_rw", 32'(bus.ex_reg_write_o), 0);
    chk("flush_stall_rd", 32'(bus.ex_rd_o), 0);
    s.flush = 0; s.stall = 0;
    cycle(s);
    for (int i = 0; i < 3; i++) begin
      s = idle(); s.stall = 1; s.mww = 1; s.mwrd = 2; s.mwdata = 32'h100 + i;
      cycle(s);
    end
    chk("stall_held_rd", 32'(bus.ex_rd_o), 7);

    // illegal op is sticky through flush and legal loads
    s = idle(); s.id.op = 4'b1111; s.id.rw = 1; s.id.rd = 3;
    cycle(s);
    chk("ill_set",    32'(bus.ill_op_o), 1);
    chk("ill_bubble", 32'(bus.ex_rd_o), 0);
    s = idle(); s.flush = 1;
    cycle(s);
    s = idle(); s.id.rw = 1; s.id.rd = 2;
    cycle(s);
    chk("ill_sticky", 32'(bus.ill_op_o), 1);

    for (int i = 0; i < 400; i++) cycle(rnd());

    // async reset mid-operation with a valid add held
    s = idle(); s.id.rw = 1; s.id.rd = 5; s.id.rs = 1; s.id.rs_data = 9;
    cycle(s);
    s.stall = 1;
    drive(s);
    #1 rst_n = 1'b0;
    #1 chk_zero("mid_reset");
    m = bubble();
    m_ill = 1'b0;
    q.delete();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk) #1;
    for (int i = 0; i < 20; i++) cycle(rnd());

    @(negedge clk);
    chk("queue_drained", 32'(q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register of the five-stage CPU; sits directly upstream of the ALU and drives its a, b and op inputs.
- Latches decoded operands and control from ID and resolves EX-stage data hazards by forwarding from EX/MEM and MEM/WB.
- Detects load-use hazards, stalls IF/ID and inserts a bubble.
- Screens ALU op codes so the ALU only ever sees a supported encoding.

Parameters:
- DW, 32, datapath width (register data, immediate, ALU operands)
- RW, 5, register address width

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- flush_i  in  1  branch/jump flush: load a bubble
- stall_i  in  1  downstream freeze: hold all contents
- id_rs_data_i  in  DW  rs value from register file
- id_rt_data_i  in  DW  rt value from register file
- id_imm_i  in  DW  immediate, already extended by ID
- id_rs_i  in  RW  rs address
- id_rt_i  in  RW  rt address
- id_rd_i  in  RW  destination address (already rt/rd-selected)
- id_alu_op_i  in  4  ALU op code
- id_alu_src_i  in  1  1 = operand B is immediate
- id_reg_write_i  in  1  control bit
- id_mem_read_i  in  1  control bit
- id_mem_write_i  in  1  control bit
- id_mem_to_reg_i  in  1  control bit
- exmem_reg_write_i  in  1  EX/MEM write-back enable
- exmem_rd_i  in  RW  EX/MEM destination
- exmem_result_i  in  DW  EX/MEM ALU result
- memwb_reg_write_i  in  1  MEM/WB write-back enable
- memwb_rd_i  in  RW  MEM/WB destination
- memwb_data_i  in  DW  MEM/WB write-back data
- alu_a_o  out  DW  ALU operand a
- alu_b_o  out  DW  ALU operand b
- alu_op_o  out  4  ALU op
- store_data_o  out  DW  forwarded rt value for stores
- ex_rd_o  out  RW  registered destination
- ex_reg_write_o  out  1  registered control bit
- ex_mem_read_o  out  1  registered control bit
- ex_mem_write_o  out  1  registered control bit
- ex_mem_to_reg_o  out  1  registered control bit
- load_use_stall_o  out  1  freeze PC and IF/ID this cycle
- ill_op_o  out  1  sticky: illegal op seen

Behaviour:
- Reset: rst_n low asynchronously clears every register to 0, which is a bubble.
  - Resulting outputs: alu_a_o=0, alu_b_o=0, alu_op_o=4'b0000, store_data_o=0, ex_rd_o=0, all ex_* controls 0, load_use_stall_o=0, ill_op_o=0.
- Latency: ID inputs appear on the registered outputs 1 cycle after the clock edge that captures them.
- Legal ALU ops:
  - 0000 add
  - 0100 sub
  - 0001 and
  - 0101 or
  - 0010 xor
  - 0110 pass b
- Load-use hazard (combinational): load_use_stall_o = ex_mem_read & (ex_rd != 0) & ((ex_rd == id_rs_i) | (ex_rd == id_rt_i)).
- Update priority at each posedge:
  1. flush_i: load bubble (all fields 0).
  2. stall_i: hold everything, including when a hazard is present.
  3. load_use_stall_o: load bubble; ID stays frozen by the stalled upstream.
  4. Otherwise load all ID inputs.
- Illegal op on load: if id_alu_op_i is not a legal code, load a bubble instead and set ill_op_o. ill_op_o stays set until reset; flush and stall do not clear it.
- Bubble definition: all data/addresses 0, op 0000, all control bits 0.
- Operand A forwarding (combinational, applied to the registered rs):
  - If exmem_reg_write_i & exmem_rd_i != 0 & exmem_rd_i == ex_rs: exmem_result_i.
  - Else if memwb_reg_write_i & memwb_rd_i != 0 & memwb_rd_i == ex_rs: memwb_data_i.
  - Else the registered rs data.
  - EX/MEM has priority over MEM/WB.
- Operand rt forwarding: same rule applied to ex_rt gives fwd_rt.
- Operand B: alu_b_o = ex_alu_src ? ex_imm : fwd_rt. store_data_o = fwd_rt always, so a store's data is forwarded even when B is the immediate.
- Register 0 is never forwarded, even when a stage claims to write it.
- Held contents re-evaluate forwarding every cycle, so during stall_i the outputs track changing EX/MEM and MEM/WB values.

Test Plan:
- Reset mid-operation: rst_n low while valid add is held → all outputs 0 immediately (asynchronously), ill_op_o=0.
- Load id_rs_data=5, id_rt_data=7, op 0100, alu_src=0, no forwarding match → next cycle alu_a_o=5, alu_b_o=7, alu_op_o=0100.
- ex_rs=3 with exmem_rd=3 (result 0x11) and memwb_rd=3 (data 0x22), both writing → alu_a_o=0x11. Drop exmem_reg_write → alu_a_o=0x22. Set rd=0 in both stages → register value.
- Load-use: lw to rd=4 in EX, ID has rs=4 → load_use_stall_o=1, next cycle EX holds a bubble (ex_reg_write_o=0). Same case with rd=0 → no stall.
- Precedence: flush_i and stall_i both 1 with valid ID → bubble loaded. stall_i alone for 3 cycles → contents held, forwarded values follow MEM/WB changes.
- Illegal op 4'b1111 loaded → bubble in EX, ill_op_o=1; it stays 1 after later flush_i and legal ops, until rst_n low.
